// File: rtl/ist_arbiter.sv
// Shares one ist unit among N_REQ streams with RID source tagging; 1-cycle registered request and response paths.
// Both registers stall when their sink is not ready; IST_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
`ifndef IST_REQ_WIDTH
`define IST_REQ_WIDTH 64
`endif
`ifndef IST_RESP_WIDTH
`define IST_RESP_WIDTH 48
`endif
`ifndef RID_WIDTH
`define RID_WIDTH 16
`endif

module ist_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 8,
    parameter int SRC_W   = $clog2(N_REQ)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic [N_REQ*`IST_REQ_WIDTH-1:0]   req_stream_rsc_dat,
    input  logic [N_REQ-1:0]                  req_stream_rsc_vld,
    output logic [N_REQ-1:0]                  req_stream_rsc_rdy,
    output logic [N_REQ*`IST_RESP_WIDTH-1:0]  resp_stream_rsc_dat,
    output logic [N_REQ-1:0]                  resp_stream_rsc_vld,
    input  logic [N_REQ-1:0]                  resp_stream_rsc_rdy,
    output logic [`IST_REQ_WIDTH-1:0]         ist_req_stream_rsc_dat,
    output logic                              ist_req_stream_rsc_vld,
    input  logic                              ist_req_stream_rsc_rdy,
    input  logic [`IST_RESP_WIDTH-1:0]        ist_resp_stream_rsc_dat,
    input  logic                              ist_resp_stream_rsc_vld,
    output logic                              ist_resp_stream_rsc_rdy,
    output logic                              err
);
    localparam int REQ_W  = `IST_REQ_WIDTH;
    localparam int RESP_W = `IST_RESP_WIDTH;
    localparam int RID_W  = `RID_WIDTH;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);

    logic                   run_q, run_d;
    logic [CNT_W-1:0]       cnt_q [N_REQ];
    logic [CNT_W-1:0]       cnt_d [N_REQ];
    logic                   ireq_vld_q, ireq_vld_d;
    logic [REQ_W-1:0]       ireq_dat_q, ireq_dat_d;
    logic [N_REQ-1:0]       rsp_vld_q, rsp_vld_d;
    logic [RESP_W-1:0]      rsp_dat_q, rsp_dat_d;
    logic                   err_q, err_d;
`ifndef IST_ARB_FIXED_PRIO_EN
    logic [SRC_W-1:0]       ptr_q, ptr_d;
`endif

    logic [N_REQ-1:0]       elig;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       deliver;
    logic                   found;
    logic [SRC_W-1:0]       win;
    logic [SRC_W:0]         idx;
    logic                   can_load;
    logic [REQ_W-1:0]       win_dat;
    logic [SRC_W-1:0]       rsp_src;
    logic [CNT_W-1:0]       rsp_pend;
    logic                   rsp_ok;
    logic                   rsp_accept;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_stream_rsc_vld[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    // Scan starts at the pointer (or at 0 for fixed priority); first eligible source wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        grant   = '0;
        win_dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef IST_ARB_FIXED_PRIO_EN
            idx = (SRC_W+1)'(k);
`else
            idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(N_REQ)) begin
                idx = idx - (SRC_W+1)'(N_REQ);
            end
`endif
            if (!found && elig[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SRC_W-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win == SRC_W'(i)) begin
                win_dat = req_stream_rsc_dat[i*REQ_W +: REQ_W];
            end
        end
        win_dat[RID_W-1 -: SRC_W] = win;
        can_load = !ireq_vld_q || ist_req_stream_rsc_rdy;
        if (run_q && can_load && found) begin
            grant[win] = 1'b1;
        end
    end

    // A response is legitimate only if its source has a request not already answered by the held response.
    always_comb begin
        rsp_src  = ist_resp_stream_rsc_dat[RID_W-1 -: SRC_W];
        deliver  = rsp_vld_q & resp_stream_rsc_rdy;
        rsp_pend = '0;
        rsp_ok   = 1'b0;
        if ({1'b0, rsp_src} < (SRC_W+1)'(N_REQ)) begin
            rsp_pend = cnt_q[rsp_src] - CNT_W'(rsp_vld_q[rsp_src]);
            rsp_ok   = (rsp_pend != '0);
        end
        ist_resp_stream_rsc_rdy = run_q && ((rsp_vld_q == '0) || (deliver != '0));
        rsp_accept = ist_resp_stream_rsc_vld && ist_resp_stream_rsc_rdy;
    end

    always_comb begin
        run_d      = 1'b1;
        ireq_vld_d = ireq_vld_q;
        ireq_dat_d = ireq_dat_q;
        rsp_vld_d  = rsp_vld_q & ~deliver;
        rsp_dat_d  = rsp_dat_q;
        err_d      = err_q;
`ifndef IST_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        if (run_q && can_load) begin
            ireq_vld_d = found;
            if (found) begin
                ireq_dat_d = win_dat;
            end
        end
`ifndef IST_ARB_FIXED_PRIO_EN
        if (grant != '0) begin
            ptr_d = (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
`endif
        if (rsp_accept) begin
            rsp_vld_d = '0;
            if (rsp_ok) begin
                rsp_vld_d[rsp_src]          = 1'b1;
                rsp_dat_d                   = ist_resp_stream_rsc_dat;
                rsp_dat_d[RID_W-1 -: SRC_W] = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(grant[i]) - CNT_W'(deliver[i]);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_q      <= 1'b0;
            ireq_vld_q <= 1'b0;
            ireq_dat_q <= '0;
            rsp_vld_q  <= '0;
            rsp_dat_q  <= '0;
            err_q      <= 1'b0;
`ifndef IST_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            ireq_vld_q <= ireq_vld_d;
            ireq_dat_q <= ireq_dat_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            err_q      <= err_d;
`ifndef IST_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign req_stream_rsc_rdy     = grant;
    assign ist_req_stream_rsc_vld = ireq_vld_q;
    assign ist_req_stream_rsc_dat = ireq_dat_q;
    assign resp_stream_rsc_vld    = rsp_vld_q;
    assign resp_stream_rsc_dat    = {N_REQ{rsp_dat_q}};
    assign err                    = err_q;

endmodule

// File: doc/ist_arbiter.md
Name: ist_arbiter

Overview:
- Shares one `ist` intersection-test unit among N_REQ requester streams (e.g. traversal lanes).
- Arbitrates request streams round-robin and tags each request's RID with its source index.
- Limits per-source outstanding requests and routes each `ist` response back to its source by RID.
- Sits between the traversal units and a single `ist` instance; all interfaces use rsc_dat/rsc_vld/rsc_rdy handshakes.

Parameters:
- N_REQ, 4, number of requester streams (2..16).
- MAX_OUT, 8, maximum in-flight requests per source (1..255).
- SRC_W, $clog2(N_REQ), width of the source tag. Derived; do not override.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- req_stream_rsc_dat  in  N_REQ*`IST_REQ_WIDTH  requester requests; source i occupies slice i.
- req_stream_rsc_vld  in  N_REQ  per-source request valid.
- req_stream_rsc_rdy  out  N_REQ  per-source request ready.
- resp_stream_rsc_dat  out  N_REQ*`IST_RESP_WIDTH  per-source responses.
- resp_stream_rsc_vld  out  N_REQ  per-source response valid.
- resp_stream_rsc_rdy  in  N_REQ  per-source response ready.
- ist_req_stream_rsc_dat  out  `IST_REQ_WIDTH  request to `ist`.
- ist_req_stream_rsc_vld  out  1  request valid to `ist`.
- ist_req_stream_rsc_rdy  in  1  `ist` ready.
- ist_resp_stream_rsc_dat  in  `IST_RESP_WIDTH  response from `ist`.
- ist_resp_stream_rsc_vld  in  1  response valid from `ist`.
- ist_resp_stream_rsc_rdy  out  1  ready to `ist`.
- err  out  1  sticky protocol error flag.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - arst_n low asynchronously clears all state: every vld output 0, every rdy output 0, err 0, RR pointer 0, outstanding counters 0, both output registers empty.
  - Data outputs reset to 0.
  - Reset mid-operation discards all in-flight state. Responses for requests issued before reset are not tracked afterwards.
- RID tagging:
  - RID occupies dat[`RID_WIDTH-1:0]. The tag is RID[`RID_WIDTH-1 -: SRC_W].
  - Requesters drive the tag bits as 0.
  - The arbiter overwrites the tag with the source index on issue and clears it to 0 on delivery. All other bits pass through unchanged.
- Request path (1-stage output register):
  - Source i is eligible when vld[i]=1 and cnt[i] < MAX_OUT.
  - Grant is evaluated when the request register is empty, or full and consumed this cycle (ist_req_stream_rsc_vld & rdy).
  - Winner is the first eligible source at or after the RR pointer, wrapping.
  - req_stream_rsc_rdy is one-hot to the winner, combinational from vld, cnt and pointer; otherwise 0.
  - On grant handshake: load the register with the tagged dat, set vld, cnt[w]++, pointer <= (w+1) mod N_REQ.
  - Latency from requester handshake to ist_req_stream_rsc_vld is 1 cycle.
  - Back-to-back issue sustains 1 request/cycle while `ist` is ready.
- Response path (1-stage output register):
  - ist_resp_stream_rsc_rdy = register empty, or register full and destination rdy high.
  - On accept: decode tag s, load the register with the tag cleared, assert resp_stream_rsc_vld[s] only.
  - Delivery handshake on source s decrements cnt[s].
- Counters:
  - Grant and delivery for the same source in the same cycle leave cnt unchanged.
  - cnt never exceeds MAX_OUT and never underflows.
- Errors:
  - An `ist` response with s >= N_REQ, or with cnt[s]==0, is accepted and dropped, and sets err.
  - err stays 1 until reset.
- Ordering: no reordering within the block. Per-source order equals `ist` output order.

Optional Feature:
- Macro: IST_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, source 0 highest; the RR pointer is removed and the winner is the lowest eligible index.
- Undefined: round-robin as above.

Test Plan:
1. Reset, then a single source 2 request with RID 0 → ist_req vld 1 cycle later, tag = 2. `ist` response with tag 2 → resp_vld[2]=1, tag cleared to 0, cnt[2] back to 0.
2. All 4 sources continuously valid, `ist` always ready → grant order 0,1,2,3,0,… (with IST_ARB_FIXED_PRIO_EN: always 0), 1 request/cycle.
3. MAX_OUT=2, source 1 valid, no `ist` responses → exactly 2 grants, then rdy[1]=0 while other sources are still granted. One response delivered → the third grant occurs.
4. Hold ist_req_stream_rsc_rdy=0 for 5 cycles → register holds stable dat/vld and no further grants occur. Release rdy → issue resumes with no request lost or duplicated.
5. resp_stream_rsc_rdy[3]=0 while an `ist` response for source 3 arrives → register holds; ist_resp_stream_rsc_rdy=0 until rdy[3]=1.
6. `ist` response with tag 3 while cnt[3]=0 → response dropped, no resp_vld asserted, err=1 and remains 1. Assert arst_n low → err=0.
